// File: rtl/csr_access_unit_pkg.sv
// Shared core parameters for the CSR access path: op encodings, FSM states
// and the default instruction tag width.
package csr_access_unit_pkg;

  localparam int TAG_WIDTH_DEFAULT = 4;
  localparam int ZIMM_WIDTH        = 5;

  typedef enum logic [1:0] {
    CSR_OP_RW  = 2'b00,
    CSR_OP_RS  = 2'b01,
    CSR_OP_RC  = 2'b10,
    CSR_OP_RSV = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_state_e;

  // Reserved encoding is never a valid CSR instruction.
  function automatic logic is_reserved_op(input csr_op_e op);
    return op == CSR_OP_RSV;
  endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// Combinational CSR update logic: new value, whether a write is needed and
// whether the access is illegal given the CSR file's permission flags.
module csr_alu
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  csr_op_e         op_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic            rs1_nonzero_i,
  input  logic [XLEN-1:0] old_value_i,
  input  logic            readable_i,
  input  logic            writeable_i,
  output logic [XLEN-1:0] new_value_o,
  output logic            write_needed_o,
  output logic            illegal_o
);

  // Select the update function; set/clear only write when rs1 is not x0.
  always_comb begin
    new_value_o    = old_value_i;
    write_needed_o = 1'b0;
    case (op_i)
      CSR_OP_RW: begin
        new_value_o    = operand_i;
        write_needed_o = 1'b1;
      end
      CSR_OP_RS: begin
        new_value_o    = old_value_i | operand_i;
        write_needed_o = rs1_nonzero_i;
      end
      CSR_OP_RC: begin
        new_value_o    = old_value_i & ~operand_i;
        write_needed_o = rs1_nonzero_i;
      end
      default: begin
        new_value_o    = old_value_i;
        write_needed_o = 1'b0;
      end
    endcase
  end

  assign illegal_o = !readable_i || is_reserved_op(op_i) ||
                     (write_needed_o && !writeable_i);

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: accepts one CSR instruction, reads the CSR file, performs
// an optional read-modify-write and returns the old value to writeback.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic                 req_imm,
  input  logic [11:0]          req_csr_addr,
  input  logic [XLEN-1:0]      req_rs1_data,
  input  logic [4:0]           req_rs1_idx,
  input  logic [4:0]           req_rd_idx,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic [11:0]          csr_read_address,
  input  logic [XLEN-1:0]      csr_read_data,
  input  logic                 csr_readable,
  input  logic                 csr_writeable,
  output logic                 csr_write_enable,
  output logic [11:0]          csr_write_address,
  output logic [XLEN-1:0]      csr_write_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_data,
  output logic [4:0]           resp_rd_idx,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic                 resp_illegal
);

  csr_state_e           state_q, state_d;
  csr_op_e              op_q;
  logic                 imm_q;
  logic [11:0]          addr_q;
  logic [XLEN-1:0]      rs1_data_q;
  logic [4:0]           rs1_idx_q;
  logic [4:0]           rd_idx_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [XLEN-1:0]      new_value_q;
  logic [XLEN-1:0]      resp_data_q;
  logic                 illegal_q;

  logic [XLEN-1:0]      operand;
  logic [XLEN-1:0]      alu_new_value;
  logic                 alu_write_needed;
  logic                 alu_illegal;
  logic                 accept;
  logic                 capture;

  assign accept  = (state_q == ST_IDLE) && req_valid && !flush;
  assign capture = (state_q == ST_READ) && !flush;

  // Immediate forms carry a 5-bit zimm in the rs1 index field.
  assign operand = imm_q ? {{(XLEN-ZIMM_WIDTH){1'b0}}, rs1_idx_q} : rs1_data_q;

  // The ALU sees live CSR read data; it is only consumed during READ.
  csr_alu #(
    .XLEN (XLEN)
  ) u_csr_alu (
    .op_i           (op_q),
    .operand_i      (operand),
    .rs1_nonzero_i  (rs1_idx_q != 5'd0),
    .old_value_i    (csr_read_data),
    .readable_i     (csr_readable),
    .writeable_i    (csr_writeable),
    .new_value_o    (alu_new_value),
    .write_needed_o (alu_write_needed),
    .illegal_o      (alu_illegal)
  );

  // State register plus request latch and READ-cycle capture of the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= CSR_OP_RW;
      imm_q       <= 1'b0;
      addr_q      <= '0;
      rs1_data_q  <= '0;
      rs1_idx_q   <= '0;
      rd_idx_q    <= '0;
      tag_q       <= '0;
      new_value_q <= '0;
      resp_data_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= csr_op_e'(req_op);
        imm_q      <= req_imm;
        addr_q     <= req_csr_addr;
        rs1_data_q <= req_rs1_data;
        rs1_idx_q  <= req_rs1_idx;
        rd_idx_q   <= req_rd_idx;
        tag_q      <= req_tag;
      end
      if (capture) begin
        new_value_q <= alu_new_value;
        illegal_q   <= alu_illegal;
        resp_data_q <= alu_illegal ? '0 : csr_read_data;
      end
    end
  end

  // Next-state logic; flush overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_READ;
      ST_READ:  state_d = (!alu_illegal && alu_write_needed) ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  assign req_ready         = (state_q == ST_IDLE);
  assign csr_read_address  = addr_q;
  // Write strobe is killed by flush or a reset landing in the WRITE cycle.
  assign csr_write_enable  = (state_q == ST_WRITE) && !flush && !reset;
  assign csr_write_address = addr_q;
  assign csr_write_data    = new_value_q;
  assign resp_valid        = (state_q == ST_RESP);
  assign resp_data         = resp_data_q;
  assign resp_rd_idx       = rd_idx_q;
  assign resp_tag          = tag_q;
  assign resp_illegal      = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a stub CSR file and write monitor.
module tb_csr_access_unit;

  localparam int XLEN = 64;
  localparam int TW   = 4;

  logic            clk = 1'b0;
  logic            reset, flush, req_valid, req_ready, req_imm;
  logic [1:0]      req_op;
  logic [11:0]     req_csr_addr, csr_read_address, csr_write_address;
  logic [XLEN-1:0] req_rs1_data, csr_read_data, csr_write_data, resp_data;
  logic [4:0]      req_rs1_idx, req_rd_idx, resp_rd_idx;
  logic [TW-1:0]   req_tag, resp_tag;
  logic            csr_readable, csr_writeable, csr_write_enable;
  logic            resp_valid, resp_ready, resp_illegal;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [11:0]     wr_last_addr;
  logic [XLEN-1:0] wr_last_data;
  int txn_no = 0;

  always #5 clk = ~clk;

  csr_access_unit #(.XLEN(XLEN), .TAG_WIDTH(TW)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_imm           (req_imm),
    .req_csr_addr      (req_csr_addr),
    .req_rs1_data      (req_rs1_data),
    .req_rs1_idx       (req_rs1_idx),
    .req_rd_idx        (req_rd_idx),
    .req_tag           (req_tag),
    .csr_read_address  (csr_read_address),
    .csr_read_data     (csr_read_data),
    .csr_readable      (csr_readable),
    .csr_writeable     (csr_writeable),
    .csr_write_enable  (csr_write_enable),
    .csr_write_address (csr_write_address),
    .csr_write_data    (csr_write_data),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_data         (resp_data),
    .resp_rd_idx       (resp_rd_idx),
    .resp_tag          (resp_tag),
    .resp_illegal      (resp_illegal)
  );

  // Count every CSR-file write the DUT actually commits.
  always @(posedge clk) begin
    if (csr_write_enable) begin
      wr_count     = wr_count + 1;
      wr_last_addr = csr_write_address;
      wr_last_data = csr_write_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic imm, input logic [11:0] addr,
                       input logic [63:0] rs1, input logic [4:0] idx);
    txn_no++;
    req_valid    = 1'b1;
    req_op       = op;
    req_imm      = imm;
    req_csr_addr = addr;
    req_rs1_data = rs1;
    req_rs1_idx  = idx;
    req_rd_idx   = 5'(txn_no + 2);
    req_tag      = TW'(txn_no);
  endtask

  task automatic run_txn(input string name, input logic [1:0] op, input logic imm,
                         input logic [11:0] addr, input logic [63:0] rs1, input logic [4:0] idx,
                         input logic [63:0] old, input logic rd_ok, input logic wr_ok,
                         input logic exp_wr, input logic [63:0] exp_wdata,
                         input logic exp_ill, input logic [63:0] exp_data, input int stall);
    logic [4:0]    exp_rd;
    logic [TW-1:0] exp_tag;
    wr_count      = 0;
    csr_read_data = old;
    csr_readable  = rd_ok;
    csr_writeable = wr_ok;
    check({name, ".ready_idle"}, 64'(req_ready), 64'd1);
    offer(op, imm, addr, rs1, idx);
    exp_rd  = 5'(txn_no + 2);
    exp_tag = TW'(txn_no);
    tick();                                   // cycle 1: READ
    req_valid = 1'b0;
    check({name, ".ready_busy"}, 64'(req_ready), 64'd0);
    check({name, ".rd_addr"}, 64'(csr_read_address), 64'(addr));
    tick();                                   // cycle 2
    if (exp_wr) begin
      check({name, ".we"}, 64'(csr_write_enable), 64'd1);
      check({name, ".waddr"}, 64'(csr_write_address), 64'(addr));
      check({name, ".wdata"}, csr_write_data, exp_wdata);
      check({name, ".early_valid"}, 64'(resp_valid), 64'd0);
      tick();                                 // cycle 3
    end
    check({name, ".valid"}, 64'(resp_valid), 64'd1);
    check({name, ".we_resp"}, 64'(csr_write_enable), 64'd0);
    check({name, ".data"}, resp_data, exp_data);
    check({name, ".illegal"}, 64'(resp_illegal), 64'(exp_ill));
    check({name, ".rd"}, 64'(resp_rd_idx), 64'(exp_rd));
    check({name, ".tag"}, 64'(resp_tag), 64'(exp_tag));
    check({name, ".writes"}, 64'(wr_count), exp_wr ? 64'd1 : 64'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({name, ".stall_valid"}, 64'(resp_valid), 64'd1);
      check({name, ".stall_data"}, resp_data, exp_data);
      check({name, ".stall_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({name, ".back_idle"}, 64'(req_ready), 64'd1);
    check({name, ".valid_drop"}, 64'(resp_valid), 64'd0);
    $display("txn %s op=%0d addr=%h resp_data=%h illegal=%0b writes=%0d",
             name, op, addr, resp_data, resp_illegal, wr_count);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_imm = 1'b0;
    req_csr_addr = '0; req_rs1_data = '0; req_rs1_idx = '0; req_rd_idx = '0; req_tag = '0;
    csr_read_data = '0; csr_readable = 1'b1; csr_writeable = 1'b1; resp_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst.ready", 64'(req_ready), 64'd1);
    check("rst.valid", 64'(resp_valid), 64'd0);
    check("rst.illegal", 64'(resp_illegal), 64'd0);
    check("rst.we", 64'(csr_write_enable), 64'd0);
    check("rst.data", resp_data, 64'd0);
    check("rst.rd_addr", 64'(csr_read_address), 64'd0);
    check("rst.tag", 64'(resp_tag), 64'd0);
    $display("txn reset ready=%0b valid=%0b", req_ready, resp_valid);

    run_txn("rw_305", 2'b00, 1'b0, 12'h305, 64'h8000_0104, 5'd1, 64'h100, 1, 1,
            1, 64'h8000_0104, 0, 64'h100, 0);
    run_txn("rs_x0", 2'b01, 1'b0, 12'h300, 64'hFF, 5'd0, 64'h88, 1, 1,
            0, 64'h0, 0, 64'h88, 0);
    run_txn("rci_08", 2'b10, 1'b1, 12'h300, 64'hFFFF, 5'd8, 64'h88, 1, 1,
            1, 64'h80, 0, 64'h88, 0);
    run_txn("rs_set", 2'b01, 1'b0, 12'h340, 64'h0F00, 5'd7, 64'h00F1, 1, 1,
            1, 64'h0FF1, 0, 64'h00F1, 0);
    run_txn("rw_ro", 2'b00, 1'b0, 12'hC00, 64'h5, 5'd2, 64'h1234, 1, 0,
            0, 64'h0, 1, 64'h0, 0);
    run_txn("rs_ro_x0", 2'b01, 1'b0, 12'hC00, 64'h5, 5'd0, 64'h1234, 1, 0,
            0, 64'h0, 0, 64'h1234, 0);
    run_txn("unmapped", 2'b01, 1'b0, 12'h7FF, 64'h0, 5'd0, 64'hDEAD, 0, 0,
            0, 64'h0, 1, 64'h0, 0);
    run_txn("rsv_op", 2'b11, 1'b0, 12'h305, 64'h1, 5'd1, 64'h77, 1, 1,
            0, 64'h0, 1, 64'h0, 0);
    run_txn("stall5", 2'b00, 1'b0, 12'h341, 64'hABCD, 5'd3, 64'h4444, 1, 1,
            1, 64'hABCD, 0, 64'h4444, 5);

    // Flush landing in WRITE: strobe suppressed, IDLE next cycle.
    wr_count = 0;
    csr_read_data = 64'h10; csr_readable = 1'b1; csr_writeable = 1'b1;
    offer(2'b00, 1'b0, 12'h305, 64'h99, 5'd4);
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("flush.we", 64'(csr_write_enable), 64'd0);
    tick();
    flush = 1'b0;
    check("flush.idle", 64'(req_ready), 64'd1);
    check("flush.valid", 64'(resp_valid), 64'd0);
    check("flush.writes", 64'(wr_count), 64'd0);
    $display("txn flush_write ready=%0b writes=%0d", req_ready, wr_count);

    // Request offered together with flush in IDLE is dropped.
    offer(2'b00, 1'b0, 12'h306, 64'h1, 5'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_idle.ready", 64'(req_ready), 64'd1);
    tick();
    check("flush_idle.valid", 64'(resp_valid), 64'd0);
    $display("txn flush_idle ready=%0b valid=%0b", req_ready, resp_valid);

    // Reset arriving in READ aborts with no response and no write.
    wr_count = 0;
    offer(2'b00, 1'b0, 12'h305, 64'h55, 5'd5);
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_read.ready", 64'(req_ready), 64'd1);
    check("rst_read.data", resp_data, 64'd0);
    repeat (3) begin
      tick();
      check("rst_read.valid", 64'(resp_valid), 64'd0);
    end
    check("rst_read.writes", 64'(wr_count), 64'd0);
    $display("txn reset_read ready=%0b writes=%0d", req_ready, wr_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have parameters: XLEN, default 64, datapath width; TAG_WIDTH, default 4, instruction tag width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  abandon the in-flight operation
- req_valid  in  1  CSR instruction offered
- req_ready  out  1  unit can accept a request
- req_op  in  2  00 RW, 01 RS, 10 RC, 11 reserved
- req_imm  in  1  use zimm as operand instead of rs1 data
- req_csr_addr  in  12  CSR address
- req_rs1_data  in  XLEN  rs1 value
- req_rs1_idx  in  5  rs1 index; also carries zimm when req_imm=1
- req_rd_idx  in  5  destination register
- req_tag  in  TAG_WIDTH  instruction tag
- csr_read_address  out  12  to the CSR file read port
- csr_read_data  in  XLEN  from the CSR file
- csr_readable  in  1  from the CSR file
- csr_writeable  in  1  from the CSR file
- csr_write_enable  out  1  to the CSR file write port
- csr_write_address  out  12  to the CSR file write port
- csr_write_data  out  XLEN  to the CSR file write port
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts the result
- resp_data  out  XLEN  old CSR value
- resp_rd_idx  out  5  destination register
- resp_tag  out  TAG_WIDTH  instruction tag
- resp_illegal  out  1  illegal-instruction exception

Function
REQ-003 SHALL implement the FSM states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 In IDLE, when req_valid=1, the unit SHALL latch all req_* fields and go to READ on the next cycle.
REQ-005 In READ, csr_read_address SHALL equal the latched address. In all other states it SHALL hold the last latched address.
REQ-006 In READ, the unit SHALL capture csr_read_data, csr_readable and csr_writeable in the same cycle.
REQ-007 The operand SHALL be the zero-extended zimm when req_imm=1, and rs1 data otherwise.
REQ-008 The new CSR value SHALL be:
- RW: operand
- RS: old | operand
- RC: old & ~operand
REQ-009 A write SHALL be needed for RW always, and for RS/RC only when the latched req_rs1_idx != 0.
REQ-010 The request SHALL be illegal when any of the following holds: csr_readable=0; the op is reserved (11); a write is needed and csr_writeable=0.
REQ-011 READ SHALL transition to WRITE when the request is legal and a write is needed. Otherwise it SHALL transition to RESP.
REQ-012 WRITE SHALL drive csr_write_enable=1 for exactly one cycle, with the address and new value, then go to RESP.
REQ-013 In RESP, resp_valid=1 SHALL hold with stable outputs until resp_ready=1; the FSM SHALL then return to IDLE on the next cycle.
REQ-014 When legal, resp_data SHALL be the old value and resp_illegal SHALL be 0. When illegal, resp_data SHALL be 0, resp_illegal SHALL be 1, and no write SHALL occur.
REQ-015 Latency from acceptance (cycle 0) SHALL be: resp_valid at cycle 3 with a write; at cycle 2 without a write or when illegal.
REQ-016 When flush=1 in any state, the FSM SHALL go to IDLE next cycle and csr_write_enable SHALL be forced to 0 in that cycle.
REQ-017 A request presented in IDLE together with flush=1 SHALL be ignored.
REQ-018 csr_write_enable SHALL never be asserted outside the WRITE state.

Reset
REQ-019 On reset, the FSM SHALL enter IDLE, and req_ready SHALL be 1 from the first cycle after reset.
REQ-020 On reset, resp_valid, resp_illegal and csr_write_enable SHALL be 0.
REQ-021 On reset, all latched fields and resp_data SHALL be 0.
REQ-022 Reset mid-operation SHALL abort the operation with no CSR write and no response.

Structure
REQ-023 The op encodings (RW/RS/RC/reserved), the FSM state encoding and the TAG_WIDTH default SHALL live in the shared core params package.
REQ-024 One combinational sub-module, csr_alu, SHALL compute the new value, the write-needed flag and the illegal flag from op, operand, old value, readable and writeable. The FSM SHALL remain in csr_access_unit.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- RW 0x305 with rs1=0x8000_0104, readable=writeable=1, old=0x100 -> one write of 0x8000_0104 at cycle 2, resp_data=0x100 at cycle 3.
- RS 0x300 with rs1_idx=0, old=0x88 -> no write, resp_data=0x88 at cycle 2.
- RC with imm, zimm=0x08, old=0x88 -> write of 0x80.
- RW 0xc00 with writeable=0 -> resp_illegal=1, resp_data=0, no write.
- Unmapped address 0x7ff (readable=0) -> illegal; reserved op 11 -> illegal.
- resp_ready held 0 for 5 cycles -> response stable, req_ready=0 throughout.
- flush in WRITE -> no write, IDLE next cycle.
- reset in READ -> IDLE, no response.
